fp_add_seq: RTL
===============

// Module: fp_add_seq
// PURPOSE
//  Parametrised, multi-cycle IEEE-754 add/subtract unit; successor to the combinational single-precision adder.
//  Generalises exponent/mantissa widths and adds a subtract mode, valid/ready handshakes,
//  round-to-nearest-even and exception flags. Sits between an operand source and a result sink in the FP datapath.
// PARAMETERS
//  EXP_W   8    exponent field width (8 -> binary32, 11 -> binary64)
//  MAN_W   23   stored fraction width (23 -> binary32, 52 -> binary64)
//  (local) W = 1+EXP_W+MAN_W total word width; BIAS = 2**(EXP_W-1)-1
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   reset: one clock; reset is synchronous and active-high
//  in_valid   in   1   operands a, b, op_sub present
//  in_ready   out  1   unit idle and able to accept
//  a          in   W   operand A, IEEE-754 packed
//  b          in   W   operand B, IEEE-754 packed
//  op_sub     in   1   0: a+b, 1: a-b (sign of b inverted on accept)
//  out_valid  out  1   result and flags valid
//  out_ready  in   1   sink accepts result
//  result     out  W   packed IEEE-754 result
//  flags      out  5   {invalid, overflow, underflow, inexact, zero}
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, result=0, flags=0; in-flight operation discarded.
//  - Accept when in_valid&&in_ready; operands and op_sub registered; in_ready drops next cycle.
//  - FSM: IDLE->UNPACK->ALIGN->ADD->NORM->ROUND->DONE, one cycle each; no stalls before DONE.
//    out_valid rises exactly 5 cycles after the accept edge. DONE holds result/flags stable until out_valid&&out_ready,
//    then ->IDLE (in_ready=1 next cycle). No accept while busy, even if out_ready is high.
//  - UNPACK: hidden bit = (exp!=0); denormal exponent treated as 1; classify zero/denormal/inf/NaN.
//  - ALIGN: larger-magnitude operand first; shift smaller right by exponent difference into MAN_W+4 bits
//    (hidden, fraction, guard, round, sticky); shifts >= MAN_W+3 collapse to sticky only.
//  - ADD: equal signs add (carry kept), else subtract smaller from larger; sign = larger operand's sign.
//  - NORM: carry -> shift right 1, exp+1 (sticky ORs shifted-out bit); else shift left by leading-zero count,
//    limited so exponent never drops below 1 (gradual underflow -> denormal, exp field 0).
//  - ROUND: RNE on guard/round/sticky; mantissa carry-out increments exponent; inexact = G|R|S.
//  - Exceptions (override datapath result):
//    any NaN input or (+inf)+(-inf) -> canonical qNaN {0,all-ones exp,1,0..0}; invalid=1 only for inf-inf or sNaN.
//    single inf -> that inf. Exponent reaching all-ones after round -> +/-inf, overflow=1, inexact=1.
//    exact zero sum of opposite signs -> +0; (-0)+(-0) -> -0. underflow=1 when result denormal/zero and inexact.
//    zero=1 whenever result magnitude is 0.
//  - Flags are per-operation (not sticky); cleared on next accept.
//  - Reset asserted mid-operation: returns to IDLE next edge, out_valid=0, no partial result emitted.
// STRUCTURE
//  - fp_pkg: FSM state enum, flag bit indices, canonical-NaN/inf constant functions of EXP_W/MAN_W.
//  - Sub-module fp_lzc #(WIDTH): combinational leading-zero counter used in NORM.
//  - Stage registers between states; no multiplier, single shifter per stage.
// TESTING (EXP_W=8, MAN_W=23)
//  - 3FC00000 + 40200000, op_sub=0 -> 40800000 (4.0), flags=0, out_valid 5 cycles after accept.
//  - 3F800000 - 3F800000 -> 00000000, zero=1; 80000000 + 80000000 -> 80000000.
//  - 7F800000 + FF800000 -> 7FC00000, invalid=1; 7F800000 + 40490FDB -> 7F800000, flags=0.
//  - 7F7FFFFF + 7F7FFFFF -> 7F800000, overflow=1, inexact=1; 00000001 + 00000001 -> 00000002, flags=0.
//  - 3F800000 + 33800000 (tie) -> 3F800000, inexact=1; 3F800001 + 33800000 -> 3F800002 (round to even).
//  - Handshake: hold out_ready=0 10 cycles -> result stable, in_ready=0; assert rst in ALIGN -> out_valid never rises,
//    in_ready=1 next cycle; back-to-back ops with out_ready=1 -> one result per 7 cycles.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point adder: FSM states,
// flag bit positions and special-value encodings for any exponent/fraction width.
`timescale 1ns/1ps
package fp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   localparam int FLAG_INVALID   = 4;
   localparam int FLAG_OVERFLOW  = 3;
   localparam int FLAG_UNDERFLOW = 2;
   localparam int FLAG_INEXACT   = 1;
   localparam int FLAG_ZERO      = 0;

   // +inf: all-ones exponent, zero fraction (right-aligned in a 64-bit word)
   function automatic logic [63:0] inf_word(input int exp_w, input int man_w);
      return ((64'd1 << exp_w) - 64'd1) << man_w;
   endfunction

   // Canonical quiet NaN: positive, all-ones exponent, only the fraction MSB set
   function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
      return inf_word(exp_w, man_w) | (64'd1 << (man_w - 1));
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
`timescale 1ns/1ps
module fp_lzc #(
   parameter int WIDTH = 27
) (
   input  logic [WIDTH-1:0]               data,
   output logic [$clog2(WIDTH+1)-1:0]     count
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   // Scan upward so the highest set bit is the last (winning) assignment
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (data[i]) count = CNT_W'(WIDTH - 1 - i);
      end
   end
endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 add/subtract with valid/ready handshakes, RNE rounding
// and per-operation exception flags. One operation in flight at a time.
`timescale 1ns/1ps
module fp_add_seq
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic                   op_sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [4:0]             flags
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int F    = MAN_W + 4;          // hidden, fraction, guard, round, sticky
   localparam int EW   = EXP_W + 1;          // headroom for carry/round exponent bumps
   localparam int LZ_W = $clog2(F + 1);
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0]     QNAN     = W'(qnan_word(EXP_W, MAN_W));
   localparam logic [W-1:0]     INF      = W'(inf_word(EXP_W, MAN_W));

   state_t             state;
   logic [W-1:0]       a_reg, b_reg;
   logic               sa_reg, sb_reg;
   logic [EXP_W-1:0]   ea_reg, eb_reg;
   logic [MAN_W:0]     ma_reg, mb_reg;
   logic               exc_reg, exc_inv_reg;
   logic [W-1:0]       exc_res_reg;
   logic               sign_reg, eff_sub_reg;
   logic [EW-1:0]      exp_reg;
   logic [F-1:0]       ml_reg, ms_reg, mn_reg;
   logic [F:0]         sum_reg;

   logic [EXP_W-1:0]   ua_exp, ub_exp;
   logic [MAN_W-1:0]   ua_frac, ub_frac;
   logic               ua_inf, ub_inf, ua_nan, ub_nan, ua_snan, ub_snan;
   logic               u_exc, u_inv;
   logic [W-1:0]       u_exc_res;

   logic               al_a_big, al_sign, al_lost;
   logic [EXP_W-1:0]   al_el, al_es;
   logic [MAN_W:0]     al_ml, al_ms;
   logic [31:0]        al_diff;
   logic [F-1:0]       al_ext, al_small;

   logic [F:0]         ad_sum;
   logic [LZ_W-1:0]    nm_lz;
   logic [EW-1:0]      nm_lim, nm_sh, nm_exp;
   logic [F-1:0]       nm_m;

   logic               rd_up, rd_inexact, rd_zero, rd_ovf, rd_sign;
   logic [MAN_W+1:0]   rd_mant;
   logic [EW-1:0]      rd_exp;
   logic [EXP_W-1:0]   rd_field;
   logic [W-1:0]       rd_res;
   logic [4:0]         rd_flags;

   // Unpack: classify operands and resolve NaN/inf cases that bypass the datapath
   always_comb begin
      ua_exp  = a_reg[W-2:MAN_W];
      ub_exp  = b_reg[W-2:MAN_W];
      ua_frac = a_reg[MAN_W-1:0];
      ub_frac = b_reg[MAN_W-1:0];
      ua_inf  = (ua_exp == EXP_ONES) && (ua_frac == '0);
      ub_inf  = (ub_exp == EXP_ONES) && (ub_frac == '0);
      ua_nan  = (ua_exp == EXP_ONES) && (ua_frac != '0);
      ub_nan  = (ub_exp == EXP_ONES) && (ub_frac != '0);
      ua_snan = ua_nan && !ua_frac[MAN_W-1];
      ub_snan = ub_nan && !ub_frac[MAN_W-1];
      u_exc     = 1'b0;
      u_inv     = 1'b0;
      u_exc_res = QNAN;
      if (ua_nan || ub_nan) begin
         u_exc = 1'b1;
         u_inv = ua_snan || ub_snan;
      end else if (ua_inf && ub_inf && (a_reg[W-1] != b_reg[W-1])) begin
         u_exc = 1'b1;
         u_inv = 1'b1;
      end else if (ua_inf) begin
         u_exc     = 1'b1;
         u_exc_res = a_reg;
      end else if (ub_inf) begin
         u_exc     = 1'b1;
         u_exc_res = b_reg;
      end
   end

   // Align: order by magnitude, right-shift the smaller mantissa keeping a sticky bit
   always_comb begin
      al_a_big = {ea_reg, ma_reg} >= {eb_reg, mb_reg};
      al_el    = al_a_big ? ea_reg : eb_reg;
      al_es    = al_a_big ? eb_reg : ea_reg;
      al_ml    = al_a_big ? ma_reg : mb_reg;
      al_ms    = al_a_big ? mb_reg : ma_reg;
      al_sign  = al_a_big ? sa_reg : sb_reg;
      al_diff  = 32'(al_el - al_es);
      al_ext   = {al_ms, 3'b000};
      al_lost  = 1'b0;
      for (int i = 0; i < F; i++) begin
         if (al_diff > 32'(i)) al_lost = al_lost | al_ext[i];
      end
      if (al_diff >= 32'(MAN_W + 3)) begin
         al_small = {{(F-1){1'b0}}, |al_ms};
      end else begin
         al_small    = al_ext >> al_diff;
         al_small[0] = al_small[0] | al_lost;
      end
   end

   // Add: magnitude add or subtract (larger minus smaller, never negative)
   always_comb begin
      if (eff_sub_reg) ad_sum = {1'b0, ml_reg} - {1'b0, ms_reg};
      else             ad_sum = {1'b0, ml_reg} + {1'b0, ms_reg};
   end

   fp_lzc #(.WIDTH(F)) u_lzc (
      .data  (sum_reg[F-1:0]),
      .count (nm_lz)
   );

   // Normalise: absorb a carry, or shift left without letting the exponent drop below 1
   always_comb begin
      nm_lim = exp_reg - EW'(1);
      nm_sh  = '0;
      if (sum_reg[F]) begin
         nm_m    = sum_reg[F:1];
         nm_m[0] = sum_reg[1] | sum_reg[0];
         nm_exp  = exp_reg + EW'(1);
      end else begin
         nm_sh  = (EW'(nm_lz) < nm_lim) ? EW'(nm_lz) : nm_lim;
         nm_m   = sum_reg[F-1:0] << nm_sh;
         nm_exp = exp_reg - nm_sh;
      end
   end

   // Round to nearest even, pack, then apply overflow and special-case overrides
   always_comb begin
      rd_up      = mn_reg[2] & (mn_reg[1] | mn_reg[0] | mn_reg[3]);
      rd_inexact = |mn_reg[2:0];
      rd_mant    = {1'b0, mn_reg[F-1:3]} + {{(MAN_W+1){1'b0}}, rd_up};
      rd_exp     = exp_reg;
      if (rd_mant[MAN_W+1]) begin
         rd_mant = rd_mant >> 1;
         rd_exp  = exp_reg + EW'(1);
      end
      rd_field = rd_mant[MAN_W] ? rd_exp[EXP_W-1:0] : '0;
      rd_zero  = (rd_mant[MAN_W:0] == '0);
      rd_sign  = (rd_zero && eff_sub_reg) ? 1'b0 : sign_reg;
      rd_ovf   = rd_mant[MAN_W] && (rd_exp >= {1'b0, EXP_ONES});
      rd_res   = {rd_sign, rd_field, rd_mant[MAN_W-1:0]};
      rd_flags = '0;
      if (exc_reg) begin
         rd_res                 = exc_res_reg;
         rd_flags[FLAG_INVALID] = exc_inv_reg;
      end else if (rd_ovf) begin
         rd_res                  = {sign_reg, INF[W-2:0]};
         rd_flags[FLAG_OVERFLOW] = 1'b1;
         rd_flags[FLAG_INEXACT]  = 1'b1;
      end else begin
         rd_flags[FLAG_INEXACT]   = rd_inexact;
         rd_flags[FLAG_UNDERFLOW] = (rd_field == '0) && rd_inexact;
         rd_flags[FLAG_ZERO]      = rd_zero;
      end
   end

   // Control FSM and stage registers; outputs are registered and held in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  a_reg    <= a;
                  b_reg    <= {b[W-1] ^ op_sub, b[W-2:0]};
                  flags    <= '0;
                  in_ready <= 1'b0;
                  state    <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               sa_reg      <= a_reg[W-1];
               sb_reg      <= b_reg[W-1];
               ea_reg      <= (ua_exp == '0) ? EXP_W'(1) : ua_exp;
               eb_reg      <= (ub_exp == '0) ? EXP_W'(1) : ub_exp;
               ma_reg      <= {ua_exp != '0, ua_frac};
               mb_reg      <= {ub_exp != '0, ub_frac};
               exc_reg     <= u_exc;
               exc_inv_reg <= u_inv;
               exc_res_reg <= u_exc_res;
               state       <= S_ALIGN;
            end
            S_ALIGN: begin
               sign_reg    <= al_sign;
               eff_sub_reg <= sa_reg ^ sb_reg;
               exp_reg     <= {1'b0, al_el};
               ml_reg      <= {al_ml, 3'b000};
               ms_reg      <= al_small;
               state       <= S_ADD;
            end
            S_ADD: begin
               sum_reg <= ad_sum;
               state   <= S_NORM;
            end
            S_NORM: begin
               mn_reg  <= nm_m;
               exp_reg <= nm_exp;
               state   <= S_ROUND;
            end
            S_ROUND: begin
               result    <= rd_res;
               flags     <= rd_flags;
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
